ap_pass_ctrl: RTL and testbench
===============================

# ap_pass_ctrl

Pass sequencer for an associative-processing array of `CELLS` parallel CAM cells, each holding `2**ADDR_BITS` words. It accepts one command at a time over a valid/ready handshake and steps a shared address through every word. On compare passes it captures per-word match tags; on write passes it drives per-cell write enables gated by those tags. It sits between the AP instruction front end and the CAM cell array, and is the only master of the array's address, key, mask, data and write-enable lines.

## Interface
- `WORD_W`, 8, CAM word width
- `ADDR_BITS`, 1, word-address bits per cell; `DEPTH = 2**ADDR_BITS`
- `CELLS`, 4, number of CAM cells driven in parallel
- `clka` in 1: the single clock; all logic is on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: controller idle, command will be accepted
- `cmd_op` in 2: command opcode
  - 00 COMPARE
  - 01 WRITE
  - 10 SET_ALL
  - 11 COMPARE_WRITE
- `cmd_key` in WORD_W: compare key
- `cmd_mask` in WORD_W: compare mask
- `cmd_data` in WORD_W: write data
- `cmd_wmask` in WORD_W: write mask
- `done` out 1: one-cycle pulse when a command completes
- `tag_count` out $clog2(CELLS*DEPTH+1): number of set tags
- `tags` out CELLS*DEPTH: tag vector; bit index is addr*CELLS + cell
- `cam_addr` out ADDR_BITS: word address broadcast to all cells
- `cam_key` out WORD_W: masked key, equal to key & mask
- `cam_mask` out WORD_W: active mask
- `cam_dina` out WORD_W: masked write data, equal to data & wmask
- `cam_we` out CELLS: per-cell write enable
- `cam_match` in CELLS: per-cell match for the current `cam_addr` (combinational from the cells)

## Operation
- State machine states: IDLE, CMP, WR, DONE.
- `cmd_ready` = (state == IDLE). A command is accepted when `cmd_valid && cmd_ready` at a rising edge.
- On accept, the controller latches the operands and sets:
  - `cam_key` = key & mask
  - `cam_dina` = data & wmask
  - `cam_mask` = mask for compare phases
- COMPARE:
  - IDLE → CMP. Address steps 0..DEPTH-1, one word per cycle.
  - Each cycle, `tags[addr*CELLS +: CELLS] <= cam_match`.
  - `tag_count` is cleared at accept and accumulates popcount(`cam_match`) each CMP cycle.
  - After the last address: → DONE.
- WRITE:
  - IDLE → WR. Address steps 0..DEPTH-1.
  - `cam_we = tags[addr*CELLS +: CELLS]`, `cam_mask` = wmask.
  - Tags and `tag_count` are unchanged. → DONE.
- SET_ALL:
  - All tags are set to 1 and `tag_count` = CELLS*DEPTH at the accept edge.
  - IDLE → DONE.
- COMPARE_WRITE:
  - Full CMP pass using key/mask, then a full WR pass using data/wmask gated by the freshly captured tags.
  - CMP → WR → DONE.
- DONE: `done` = 1 for one cycle, then → IDLE.
- Outside WR, `cam_we` is all 0. In IDLE and DONE, `cam_addr` is 0.
- A WRITE with no tags set still runs DEPTH cycles, with `cam_we` all 0.
- Address counter: ADDR_BITS wide. Leave CMP/WR when addr == DEPTH-1; the address wraps to 0 when entering WR and DONE.
- `cmd_valid` held during a busy pass is ignored; there is no queueing.

## Timing
- Accept at edge k (the end of cycle k).
- COMPARE and WRITE:
  - Pass runs in cycles k+1..k+DEPTH, with `cam_addr` = cycle − (k+1).
  - `done` in cycle k+DEPTH+1.
  - `cmd_ready` is high again in cycle k+DEPTH+2.
- COMPARE_WRITE:
  - CMP in cycles k+1..k+DEPTH, WR in cycles k+DEPTH+1..k+2·DEPTH.
  - `done` in cycle k+2·DEPTH+1.
- SET_ALL: `done` in cycle k+1.
- Tag capture occurs at the edge ending each CMP cycle. The cell write occurs at the edge ending each WR cycle.
- Reset (`rst_n` low, any time, including mid-pass), asynchronously:
  - state IDLE, `cam_we` 0, `cam_addr` 0
  - `cam_key`, `cam_mask`, `cam_dina` 0
  - `tags` 0, `tag_count` 0, `done` 0
  - `cmd_ready` 1
- No command is accepted while `rst_n` is low. No `done` is produced for an aborted command.

## Test plan
Parameters for all scenarios: WORD_W=8, ADDR_BITS=1, CELLS=4.

- Reset: pulse `rst_n` low asynchronously mid-cycle → all outputs immediately at reset values; `cmd_ready`=1.
- SET_ALL, then WRITE data=0xA5 wmask=0xFF, with real cells:
  - `done` 1 cycle after SET_ALL accept; `tag_count`=8.
  - WRITE: `cam_we`=4'hF in both pass cycles; `done` at k+3; all 8 words read 0xA5.
- COMPARE with a mock array driving `cam_match`=4'b0101 at addr 0 and 4'b0011 at addr 1:
  - `tags`=8'b0011_0101, `tag_count`=4.
  - A following WRITE drives `cam_we`=0101 at addr 0, then 0011 at addr 1.
- COMPARE_WRITE on words all 0x05, key=0x05 mask=0x0F data=0x30 wmask=0xF0:
  - `done` at k+5; `cam_dina`=0x30; every word reads 0x35.
  - A follow-up COMPARE with key=0xA5 mask=0xFF gives `tag_count`=0.
- Back-to-back: `cmd_valid` held high with COMPARE then WRITE:
  - Second command is accepted exactly in the IDLE cycle after `done`.
  - `cmd_ready` is 0 throughout both passes.
- `rst_n` asserted in cycle k+3 of COMPARE_WRITE:
  - `cam_we` drops to 0 immediately; tags cleared.
  - No `done`; `cmd_ready`=1 while reset is held.

Source files
------------

// File: rtl/ap_pass_ctrl_if.sv
// ap_pass_ctrl_if: bundles the command handshake, the tag/status outputs and
// the CAM array bus of the AP pass sequencer.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while the sequencer is idle;
// cmd_valid seen while cmd_ready is low is ignored (nothing is queued).
//
// Modports:
//   slave  - the sequencer (ap_pass_ctrl): takes commands, masters the array
//   master - the front end / array side: issues commands, returns cam_match
interface ap_pass_ctrl_if #(
  parameter int WORD_W    = 8,
  parameter int ADDR_BITS = 1,
  parameter int CELLS     = 4
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int TCW   = $clog2(CELLS * DEPTH + 1);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [WORD_W-1:0]        cmd_key;
  logic [WORD_W-1:0]        cmd_mask;
  logic [WORD_W-1:0]        cmd_data;
  logic [WORD_W-1:0]        cmd_wmask;
  logic                     done;
  logic [TCW-1:0]           tag_count;
  logic [CELLS*DEPTH-1:0]   tags;
  logic [ADDR_BITS-1:0]     cam_addr;
  logic [WORD_W-1:0]        cam_key;
  logic [WORD_W-1:0]        cam_mask;
  logic [WORD_W-1:0]        cam_dina;
  logic [CELLS-1:0]         cam_we;
  logic [CELLS-1:0]         cam_match;

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_mask, cmd_data, cmd_wmask, cam_match,
    output cmd_ready, done, tag_count, tags,
    output cam_addr, cam_key, cam_mask, cam_dina, cam_we
  );

  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_mask, cmd_data, cmd_wmask, cam_match,
    input  cmd_ready, done, tag_count, tags,
    input  cam_addr, cam_key, cam_mask, cam_dina, cam_we
  );
endinterface

// File: rtl/ap_pass_ctrl.sv
// ap_pass_ctrl: pass sequencer for an associative-processing array of CELLS
// CAM cells of DEPTH words each. One command at a time; each pass walks the
// shared word address 0..DEPTH-1. Compare passes capture per-word match tags,
// write passes drive per-cell write enables gated by those tags.
//
// Ports:
//   clka      - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - ap_pass_ctrl_if.slave: command handshake, tags/tag_count/done,
//               CAM address/key/mask/data/write-enable, cam_match return
//   state_dbg - current FSM state (0 IDLE, 1 CMP, 2 WR, 3 DONE)
module ap_pass_ctrl #(
  parameter int WORD_W    = 8,
  parameter int ADDR_BITS = 1,
  parameter int CELLS     = 4
) (
  input  logic           clka,
  input  logic           rst_n,
  ap_pass_ctrl_if.slave  bus,
  output logic [1:0]     state_dbg
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int TCW   = $clog2(CELLS * DEPTH + 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  localparam logic [1:0] OP_CMP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CW  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   cw_q;      // COMPARE_WRITE: follow CMP with WR
  logic [WORD_W-1:0]      wmask_q;   // write mask, loaded onto cam_mask for WR
  logic [WORD_W-1:0]      key_q;
  logic [WORD_W-1:0]      mask_q;
  logic [WORD_W-1:0]      dina_q;
  logic [CELLS*DEPTH-1:0] tags_q;
  logic [TCW-1:0]         count_q;
  logic                   done_q;

  function automatic logic [TCW-1:0] popcnt(input logic [CELLS-1:0] v);
    logic [TCW-1:0] s;
    s = '0;
    for (int i = 0; i < CELLS; i++) s = s + TCW'(v[i]);
    return s;
  endfunction

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      cw_q    <= 1'b0;
      wmask_q <= '0;
      key_q   <= '0;
      mask_q  <= '0;
      dina_q  <= '0;
      tags_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            key_q   <= bus.cmd_key & bus.cmd_mask;
            dina_q  <= bus.cmd_data & bus.cmd_wmask;
            wmask_q <= bus.cmd_wmask;
            mask_q  <= bus.cmd_mask;
            addr_q  <= '0;
            cw_q    <= (bus.cmd_op == OP_CW);
            case (bus.cmd_op)
              OP_CMP, OP_CW: begin
                count_q <= '0;
                state   <= CMP;
              end
              OP_WR: begin
                mask_q <= bus.cmd_wmask;
                state  <= WR;
              end
              OP_SET: begin
                tags_q  <= '1;
                count_q <= TCW'(CELLS * DEPTH);
                done_q  <= 1'b1;
                state   <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
        CMP: begin
          // Capture this word's matches at the edge ending the cycle.
          tags_q[int'(addr_q)*CELLS +: CELLS] <= bus.cam_match;
          count_q <= count_q + popcnt(bus.cam_match);
          if (addr_q == LAST_ADDR) begin
            addr_q <= '0;
            if (cw_q) begin
              mask_q <= wmask_q;
              state  <= WR;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            addr_q <= addr_q + ADDR_BITS'(1);
          end
        end
        WR: begin
          if (addr_q == LAST_ADDR) begin
            addr_q <= '0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            addr_q <= addr_q + ADDR_BITS'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write enables are a direct decode of the registered state, address and
  // tags, so they follow tags captured on the final CMP edge of a
  // COMPARE_WRITE and drop the instant reset returns the FSM to IDLE.
  assign bus.cam_we    = (state == WR) ? tags_q[int'(addr_q)*CELLS +: CELLS] : '0;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.done      = done_q;
  assign bus.tags      = tags_q;
  assign bus.tag_count = count_q;
  assign bus.cam_addr  = addr_q;
  assign bus.cam_key   = key_q;
  assign bus.cam_mask  = mask_q;
  assign bus.cam_dina  = dina_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_ap_pass_ctrl.sv
module tb_ap_pass_ctrl;
  localparam int WORD_W = 8, ADDR_BITS = 1, CELLS = 4, DEPTH = 2;
  localparam logic [1:0] OP_CMP = 2'b00, OP_WR = 2'b01, OP_SET = 2'b10, OP_CW = 2'b11;

  // ---------------- clock / reset ----------------
  logic clka = 1'b0;
  logic rst_n = 1'b0;
  always #5 clka = ~clka;

  ap_pass_ctrl_if #(.WORD_W(WORD_W), .ADDR_BITS(ADDR_BITS), .CELLS(CELLS)) bus ();
  logic [1:0] state_dbg;

  ap_pass_ctrl #(.WORD_W(WORD_W), .ADDR_BITS(ADDR_BITS), .CELLS(CELLS)) dut (
    .clka(clka), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- CAM cell array (environment) ----------------
  // word (addr a, cell c) lives at cell_img[(a*4+c)*8 +: 8]
  logic [63:0] cell_img;
  logic [63:0] pre_img = '0;
  logic        pre_go = 1'b0;
  logic        mock_on = 1'b0;
  logic [7:0]  mock_tags = '0;
  logic [3:0]  match_w;

  always_comb begin
    match_w = '0;
    for (int c = 0; c < CELLS; c++) begin
      if (mock_on) match_w[c] = mock_tags[int'(bus.cam_addr)*CELLS + c];
      else match_w[c] = ((cell_img[(int'(bus.cam_addr)*CELLS + c)*8 +: 8] & bus.cam_mask) == bus.cam_key);
    end
  end
  assign bus.cam_match = match_w;

  always @(posedge clka) begin
    if (pre_go) cell_img <= pre_img;
    else
      for (int c = 0; c < CELLS; c++)
        if (bus.cam_we[c])
          cell_img[(int'(bus.cam_addr)*CELLS + c)*8 +: 8] <=
            (cell_img[(int'(bus.cam_addr)*CELLS + c)*8 +: 8] & ~bus.cam_mask) | (bus.cam_dina & bus.cam_mask);
  end

  // ---------------- reference model ----------------
  logic [63:0] exp_img;
  logic [7:0]  exp_tags;
  int          exp_count;
  logic [WORD_W-1:0] exp_q[$];   // expected cam_key / cam_dina / cam_mask after a command
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [7:0] model_cmp(input logic [63:0] img, input logic [7:0] key, input logic [7:0] mask);
    logic [7:0] t;
    for (int w = 0; w < 8; w++) t[w] = (((img[w*8 +: 8] ^ key) & mask) == 8'h00);
    return t;
  endfunction

  function automatic logic [63:0] model_wr(input logic [63:0] img, input logic [7:0] t,
                                           input logic [7:0] data, input logic [7:0] wmask);
    logic [63:0] r;
    r = img;
    for (int w = 0; w < 8; w++)
      if (t[w]) r[w*8 +: 8] = (img[w*8 +: 8] & ~wmask) | (data & wmask);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.cmd_ready, 1);
    chk({tag, "_we"}, bus.cam_we, 0);
    chk({tag, "_addr"}, bus.cam_addr, 0);
    chk({tag, "_key"}, bus.cam_key, 0);
    chk({tag, "_mask"}, bus.cam_mask, 0);
    chk({tag, "_dina"}, bus.cam_dina, 0);
    chk({tag, "_tags"}, bus.tags, 0);
    chk({tag, "_count"}, bus.tag_count, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [63:0] v);
    @(negedge clka); pre_img = v; pre_go = 1'b1;
    @(negedge clka); pre_go = 1'b0;
    exp_img = v;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] key, input logic [7:0] mask,
                         input logic [7:0] data, input logic [7:0] wmask);
    logic [7:0] t_cmp, we_tags;
    int lat, wr_first, a;
    logic [3:0] e_we;
    int e_addr;
    t_cmp    = mock_on ? mock_tags : model_cmp(exp_img, key, mask);
    lat      = (op == OP_CW) ? 2*DEPTH + 1 : (op == OP_SET) ? 1 : DEPTH + 1;
    wr_first = (op == OP_WR) ? 1 : (op == OP_CW) ? DEPTH + 1 : 0;
    we_tags  = (op == OP_CW) ? t_cmp : exp_tags;
    @(negedge clka);
    chk("ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_key = key; bus.cmd_mask = mask;
    bus.cmd_data = data; bus.cmd_wmask = wmask;
    @(posedge clka);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clka);
      if (cyc == 1) bus.cmd_valid = 1'b0;
      e_we = '0; e_addr = 0;
      if (wr_first != 0 && cyc >= wr_first && cyc < wr_first + DEPTH) begin
        a = cyc - wr_first; e_we = we_tags[a*4 +: 4]; e_addr = a;
      end else if ((op == OP_CMP || op == OP_CW) && cyc <= DEPTH) begin
        e_addr = cyc - 1;
      end
      chk("pass_we", bus.cam_we, e_we);
      chk("pass_addr", bus.cam_addr, e_addr);
      chk("pass_done", bus.done, (cyc == lat));
      chk("pass_busy", bus.cmd_ready, 0);
    end
    case (op)
      OP_CMP: exp_tags = t_cmp;
      OP_WR:  exp_img = model_wr(exp_img, exp_tags, data, wmask);
      OP_SET: exp_tags = 8'hFF;
      default: begin exp_tags = t_cmp; exp_img = model_wr(exp_img, t_cmp, data, wmask); end
    endcase
    exp_count = $countones(exp_tags);
    exp_q.push_back(key & mask);
    exp_q.push_back(data & wmask);
    exp_q.push_back((op == OP_WR || op == OP_CW) ? wmask : mask);
    @(negedge clka);
    chk("ready_back", bus.cmd_ready, 1);
    chk("done_pulse", bus.done, 0);
    chk("tags", bus.tags, exp_tags);
    chk("tag_count", bus.tag_count, exp_count);
    chk("cells", cell_img, exp_img);
    chk("cam_key", bus.cam_key, exp_q.pop_front());
    chk("cam_dina", bus.cam_dina, exp_q.pop_front());
    chk("cam_mask", bus.cam_mask, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] r_op;
    logic [7:0] r_key;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_key = '0; bus.cmd_mask = '0;
    bus.cmd_data = '0; bus.cmd_wmask = '0;
    exp_img = '0; exp_tags = '0; exp_count = 0;

    // power-on reset
    #12;
    chk_reset_vals("por");
    @(negedge clka); rst_n = 1'b1;
    preload(64'h0);

    // SET_ALL, then an asynchronous mid-cycle reset pulse while idle
    run_cmd(OP_SET, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("set_count8", bus.tag_count, 8);
    @(posedge clka); #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clka); rst_n = 1'b1;
    exp_tags = '0; exp_count = 0;

    // SET_ALL then WRITE 0xA5 to every word
    run_cmd(OP_SET, 8'h00, 8'h00, 8'h00, 8'h00);
    run_cmd(OP_WR, 8'h00, 8'h00, 8'hA5, 8'hFF);
    chk("wr_all_a5", cell_img, {8{8'hA5}});

    // mock array: 0101 at addr 0, 0011 at addr 1
    mock_on = 1'b1; mock_tags = 8'b0011_0101;
    run_cmd(OP_CMP, 8'h11, 8'hFF, 8'h00, 8'h00);
    chk("mock_tags", bus.tags, 8'b0011_0101);
    chk("mock_count", bus.tag_count, 4);
    run_cmd(OP_WR, 8'h00, 8'h00, 8'h5A, 8'h0F);
    mock_on = 1'b0;

    // COMPARE_WRITE on words all 0x05
    preload({8{8'h05}});
    run_cmd(OP_CW, 8'h05, 8'h0F, 8'h30, 8'hF0);
    chk("cw_dina", bus.cam_dina, 8'h30);
    chk("cw_all_35", cell_img, {8{8'h35}});
    run_cmd(OP_CMP, 8'hA5, 8'hFF, 8'h00, 8'h00);
    chk("cw_follow_cnt0", bus.tag_count, 0);

    // back-to-back: cmd_valid held, COMPARE then WRITE
    preload({8{8'h05}});
    @(negedge clka);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_CMP; bus.cmd_key = 8'h05; bus.cmd_mask = 8'hFF;
    @(posedge clka);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clka);
      if (cyc == 1) begin bus.cmd_op = OP_WR; bus.cmd_data = 8'h77; bus.cmd_wmask = 8'h0F; end
      chk("b2b_ready", bus.cmd_ready, (cyc == 4));
      chk("b2b_done", bus.done, (cyc == 3 || cyc == 7));
      if (cyc == 5 || cyc == 6) chk("b2b_we", bus.cam_we, 4'hF);
      if (cyc == 7) bus.cmd_valid = 1'b0;
    end
    exp_tags = 8'hFF; exp_count = 8; exp_img = {8{8'h07}};
    @(negedge clka);
    chk("b2b_cells", cell_img, exp_img);
    chk("b2b_tags", bus.tags, exp_tags);

    // reset in cycle k+3 of a COMPARE_WRITE
    preload({8{8'h05}});
    @(negedge clka);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_CW; bus.cmd_key = 8'h05; bus.cmd_mask = 8'h0F;
    bus.cmd_data = 8'h30; bus.cmd_wmask = 8'hF0;
    @(posedge clka);
    @(negedge clka); bus.cmd_valid = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk("abort_we_pre", bus.cam_we, 4'hF);
    #1 rst_n = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_WR;
    #1 chk_reset_vals("abort");
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clka);
      chk("abort_no_done", bus.done, 0);
      chk("abort_ready", bus.cmd_ready, 1);
      chk("abort_idle", state_dbg, 0);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clka); rst_n = 1'b1;
    exp_tags = '0; exp_count = 0;
    chk("abort_cells", cell_img, exp_img);

    // randomized commands against the model
    preload({$urandom, $urandom});
    for (int i = 0; i < 24; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_key = ($urandom_range(0, 1) == 1) ? exp_img[$urandom_range(0, 7)*8 +: 8] : 8'($urandom);
      run_cmd(r_op, r_key, 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
